// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB4 requester with alignment check and ACCESS-phase timeout
module apb_cmd_master #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic          i_cmd_write,
  input  logic [DW-1:0] i_cmd_wdata,
  input  logic [SW-1:0] i_cmd_strb,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_rsp_err,
  output logic          o_rsp_timeout,
  output logic [AW-1:0] o_paddr,
  output logic          o_pwrite,
  output logic          o_psel,
  output logic          o_penable,
  output logic [DW-1:0] o_pwdata,
  output logic [SW-1:0] o_pstrb,
  input  logic [DW-1:0] i_prdata,
  input  logic          i_pready,
  input  logic          i_pslverr
);
  localparam int AL = $clog2(DW / 8);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_M1 = TIMEOUT > 0 ? TIMEOUT - 1 : 0;
  localparam logic [AW-1:0] AMASK = AW'((1 << AL) - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          timeout_hit;
  assign o_cmd_ready = state_q == IDLE;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CW'(TO_M1));
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      o_psel        <= 1'b0;
      o_penable     <= 1'b0;
      o_pwrite      <= 1'b0;
      o_paddr       <= '0;
      o_pwdata      <= '0;
      o_pstrb       <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_cmd_valid) begin
          if ((i_cmd_addr & AMASK) != '0) begin
            // misaligned: answer directly, never touch the bus
            state_q       <= RESP;
            o_rsp_valid   <= 1'b1;
            o_rsp_err     <= 1'b1;
            o_rsp_timeout <= 1'b0;
            o_rsp_rdata   <= '0;
          end else begin
            state_q  <= SETUP;
            o_psel   <= 1'b1;
            o_paddr  <= i_cmd_addr;
            o_pwrite <= i_cmd_write;
            o_pwdata <= i_cmd_wdata;
            o_pstrb  <= i_cmd_write ? i_cmd_strb : '0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          o_penable <= 1'b1;
          cnt_q     <= '0;
        end
        ACCESS: begin
          if (i_pready) begin
            state_q       <= RESP;
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_rsp_err     <= i_pslverr;
            o_rsp_timeout <= 1'b0;
            o_rsp_rdata   <= (!o_pwrite && !i_pslverr) ? i_prdata : '0;
          end else if (timeout_hit) begin
            state_q       <= RESP;
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_rsp_err     <= 1'b1;
            o_rsp_timeout <= 1'b1;
            o_rsp_rdata   <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: if (i_rsp_ready) begin
          state_q     <= IDLE;
          o_rsp_valid <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
